mips_debug_ctrl: RTL and testbench
==================================

Name: mips_debug_ctrl

Overview:
Parametrised front-panel debug controller for the MIPS core. Converts KEY presses and SW values into:
- PC-advance enables: single step, N-step burst, free run.
- A sequential manual register preload of GPRs 1..NREG_LOAD.
- A selectable register readout on LEDR.

It sits between the board I/O and the core's PC register, GPR write port and debug read port.

Parameters:
XLEN, 32, datapath width of load_data and dbg_rd_data
SW_W, 10, switch bank width (at least STEP_CNT_W+1)
LED_W, 10, LED bank width (at most XLEN)
NREG_LOAD, 3, number of GPRs preloaded (1..31); also the display range
STEP_CNT_W, 8, burst-count width, taken from SW[STEP_CNT_W-1:0]

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
SW  in  SW_W  switch inputs
KEY  in  4  push buttons, active-low: [0] step, [1] load, [2] display select, [3] run/stop
dbg_rd_data  in  XLEN  GPR value at dbg_rd_addr (combinational read)
pc_en  out  1  PC advance enable, high one cycle per instruction
load_we  out  1  GPR manual write strobe
load_addr  out  5  GPR manual write address
load_data  out  XLEN  GPR manual write data
dbg_rd_addr  out  5  GPR debug read address
LEDR  out  LED_W  registered display of dbg_rd_data[LED_W-1:0]
state_o  out  3  FSM state: LOAD=0, IDLE=1, STEP=2, BURST=3, RUN=4

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset values: state=LOAD, load_idx=1, pc_en=0, load_we=0, load_addr=0, load_data=0, dbg_rd_addr=1, LEDR=0, all prev_key=1, burst_cnt=0.
- Edge detect: edge_k = prev_key[k] & ~KEY[k], evaluated in the same cycle. prev_key is registered every cycle. A held key produces exactly one edge.
- Edge priority in one cycle: KEY[3] > KEY[0] > KEY[1]. KEY[2] is independent of the FSM.
- pc_en = (state==STEP) | (state==BURST) | (state==RUN). It is a Moore output of the registered state.
- An edge detected in cycle t changes state at the t+1 clock edge.

LOAD state:
- edge_1: in the next cycle load_we=1 for one cycle, load_addr=load_idx, load_data=zero-extended SW.
- After the write with load_idx==NREG_LOAD: load_idx←1 and state→IDLE. Otherwise load_idx increments.
- KEY[0] and KEY[3] are ignored in LOAD.

IDLE state:
- edge_3 → RUN.
- edge_0 with SW[SW_W-1]=0 → STEP.
- edge_0 with SW[SW_W-1]=1 → BURST, with burst_cnt←SW[STEP_CNT_W-1:0]. If the count is 0, stay in IDLE and emit no pulse.
- edge_1 → LOAD with load_idx=1 (reload sequence).

STEP state: lasts one cycle, then IDLE. Exactly one pc_en cycle per press.

BURST state:
- pc_en is high for exactly N consecutive cycles; burst_cnt decrements each cycle.
- Exit to IDLE after the cycle in which burst_cnt==1.
- edge_3 aborts to IDLE. The abort cycle itself still has pc_en=1; pc_en is 0 from the next cycle.

RUN state:
- pc_en is high every cycle.
- edge_3 → IDLE.
- KEY[0] and KEY[1] are ignored.

Display:
- edge_2 in any state: dbg_rd_addr increments, wrapping NREG_LOAD→1.
- LEDR ← dbg_rd_data[LED_W-1:0] every cycle, giving one cycle of latency.

Other boundary rules:
- load_we never coincides with pc_en.
- reset asserted mid-BURST or mid-RUN drops pc_en to 0 in the next cycle and returns to LOAD.

Optional Feature:
MIPS_DBG_BREAKPOINT_EN

When defined:
- Adds input ports pc_in (XLEN), bp_pc (XLEN) and bp_valid (1).
- In RUN or BURST, if bp_valid and pc_in==bp_pc, state→IDLE at the next edge and pc_en is 0 in that same cycle (combinational mask). The instruction at bp_pc is therefore not advanced past.
- In IDLE, STEP always steps, even when pc_in==bp_pc, so execution can leave a breakpoint.

When undefined:
- No extra ports.
- RUN and BURST stop only on KEY[3] or count exhaustion.

Test Plan:
- Reset, then three KEY[1] presses with SW=5, 10, 0x3FF → load_we pulses with (addr,data) = (1,5), (2,10), (3,0x3FF); state_o=1 after the third press.
- IDLE, SW[9]=0, one KEY[0] press held for 20 cycles → pc_en high for exactly 1 cycle, one cycle after the edge.
- IDLE, SW[9]=1, SW[7:0]=7, press KEY[0] → exactly 7 consecutive pc_en cycles, then state_o=1. Repeat with SW[7:0]=0 → no pc_en and state stays IDLE.
- KEY[3] press, wait 50 cycles, KEY[3] press → pc_en high continuously for the RUN interval, low afterwards. A simultaneous KEY[0] edge on the stop press is ignored.
- After load, dbg_rd_data driven = 0x155 at addr 2; press KEY[2] once → dbg_rd_addr=2 and LEDR=0x155 one cycle later. Two more presses → dbg_rd_addr wraps to 1.
- With MIPS_DBG_BREAKPOINT_EN: bp_pc=0x10, bp_valid=1, pc_in incrementing by 4 per pc_en, RUN from 0 → exactly 4 pc_en cycles, pc_en=0 when pc_in=0x10, state_o=1. A following KEY[0] step produces one pc_en.

Source files
------------

// File: rtl/mips_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_debug_ctrl
//  Description : Front-panel debug controller for the MIPS core. Turns KEY
//                presses and SW values into PC-advance enables (single step,
//                N-step burst, free run) and a sequential preload of GPRs
//                1..NREG_LOAD. It also drives a selectable register readout
//                on LEDR.
//                Optional feature macro: MIPS_DBG_BREAKPOINT_EN adds a PC
//                breakpoint comparator that halts RUN/BURST.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_debug_ctrl #(
    parameter int XLEN       = 32,
    parameter int SW_W       = 10,
    parameter int LED_W      = 10,
    parameter int NREG_LOAD  = 3,
    parameter int STEP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SW_W-1:0]       SW,
    input  logic [3:0]            KEY,
    input  logic [XLEN-1:0]       dbg_rd_data,
`ifdef MIPS_DBG_BREAKPOINT_EN
    input  logic [XLEN-1:0]       pc_in,
    input  logic [XLEN-1:0]       bp_pc,
    input  logic                  bp_valid,
`endif
    output logic                  pc_en,
    output logic                  load_we,
    output logic [4:0]            load_addr,
    output logic [XLEN-1:0]       load_data,
    output logic [4:0]            dbg_rd_addr,
    output logic [LED_W-1:0]      LEDR,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_STEP  = 3'd2,
        ST_BURST = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NREG_LOAD);

    state_t                  state;
    logic [3:0]              prev_key;
    logic [3:0]              key_edge;
    logic [4:0]              load_idx;
    logic [STEP_CNT_W-1:0]   burst_cnt;
    logic                    bp_hit;

    // Keys are active-low: a press is a high-to-low transition seen this cycle.
    assign key_edge = prev_key & ~KEY;

`ifdef MIPS_DBG_BREAKPOINT_EN
    assign bp_hit = bp_valid && (pc_in == bp_pc);
`else
    assign bp_hit = 1'b0;
`endif

    // Breakpoint masks RUN/BURST immediately; STEP is left alone so the user
    // can always step off a breakpoint.
    assign pc_en   = (state == ST_STEP) |
                     (((state == ST_BURST) | (state == ST_RUN)) & ~bp_hit);
    assign state_o = state;

    // Unused high bits of the debug read bus are folded into a sink signal.
    generate
        if (LED_W < XLEN) begin : g_unused_rd
            logic unused_rd_bits;
            assign unused_rd_bits = ^dbg_rd_data[XLEN-1:LED_W];
        end
    endgenerate

    // Main control FSM: key history, load sequencing and burst counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_LOAD;
            prev_key  <= 4'hF;
            load_idx  <= 5'd1;
            load_we   <= 1'b0;
            load_addr <= 5'd0;
            load_data <= '0;
            burst_cnt <= '0;
        end else begin
            prev_key <= KEY;
            load_we  <= 1'b0;
            case (state)
                ST_LOAD: begin
                    // Step and run keys are deliberately ignored while loading.
                    if (key_edge[1]) begin
                        load_we   <= 1'b1;
                        load_addr <= load_idx;
                        load_data <= XLEN'(SW);
                        if (load_idx == LAST_IDX) begin
                            load_idx <= 5'd1;
                            state    <= ST_IDLE;
                        end else begin
                            load_idx <= load_idx + 5'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (key_edge[3]) begin
                        state <= ST_RUN;
                    end else if (key_edge[0]) begin
                        if (!SW[SW_W-1]) begin
                            state <= ST_STEP;
                        end else if (SW[STEP_CNT_W-1:0] != '0) begin
                            state     <= ST_BURST;
                            burst_cnt <= SW[STEP_CNT_W-1:0];
                        end
                    end else if (key_edge[1]) begin
                        state    <= ST_LOAD;
                        load_idx <= 5'd1;
                    end
                end
                ST_STEP: begin
                    state <= ST_IDLE;
                end
                ST_BURST: begin
                    burst_cnt <= burst_cnt - STEP_CNT_W'(1);
                    if (key_edge[3] || bp_hit || (burst_cnt == STEP_CNT_W'(1))) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (key_edge[3] || bp_hit) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    // Display path: KEY[2] cycles the read address, LEDR mirrors the read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_rd_addr <= 5'd1;
            LEDR        <= '0;
        end else begin
            if (key_edge[2]) begin
                dbg_rd_addr <= (dbg_rd_addr == LAST_IDX) ? 5'd1 : dbg_rd_addr + 5'd1;
            end
            LEDR <= dbg_rd_data[LED_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_debug_ctrl
//  Description : Self-checking bench for mips_debug_ctrl: vector table,
//                directed multi-cycle sequences and a randomized operation
//                stream checked against an operation-level reference model.
//                Breakpoint checks are built when MIPS_DBG_BREAKPOINT_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_debug_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  SW;
    logic [3:0]  KEY;
    logic [31:0] dbg_rd_data;
    logic        pc_en;
    logic        load_we;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic [4:0]  dbg_rd_addr;
    logic [9:0]  LEDR;
    logic [2:0]  state_o;
`ifdef MIPS_DBG_BREAKPOINT_EN
    logic [31:0] pc_in;
    logic [31:0] bp_pc;
    logic        bp_valid;
`endif

    always #5 clk = ~clk;

    mips_debug_ctrl #(
        .XLEN(32), .SW_W(10), .LED_W(10), .NREG_LOAD(3), .STEP_CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .SW(SW), .KEY(KEY), .dbg_rd_data(dbg_rd_data),
`ifdef MIPS_DBG_BREAKPOINT_EN
        .pc_in(pc_in), .bp_pc(bp_pc), .bp_valid(bp_valid),
`endif
        .pc_en(pc_en), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .dbg_rd_addr(dbg_rd_addr), .LEDR(LEDR),
        .state_o(state_o)
    );

    // Register file seen through the debug read port
    logic [31:0] gpr [0:31];
    assign dbg_rd_data = gpr[dbg_rd_addr];

`ifdef MIPS_DBG_BREAKPOINT_EN
    // Core PC model: advances by one instruction per enabled cycle
    always @(posedge clk) begin
        if (reset) pc_in <= 32'd0;
        else if (pc_en) pc_in <= pc_in + 32'd4;
    end
`endif

    // pc_en activity monitor
    int   pc_cnt = 0;
    int   pc_bursts = 0;
    int   overlap_cnt = 0;
    logic pc_prev = 1'b0;
    always @(negedge clk) begin
        if (pc_en) begin
            pc_cnt++;
            if (!pc_prev) pc_bursts++;
        end
        if (pc_en && load_we) overlap_cnt++;
        pc_prev = pc_en;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        pc_cnt    = 0;
        pc_bursts = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        KEY   = 4'hF;
        SW    = 10'd0;
        tick(2);
        reset = 1'b0;
    endtask

    // Three load presses; expects writes to GPR 1, 2, 3 then IDLE.
    task automatic do_load(input logic [9:0] v0, input logic [9:0] v1, input logic [9:0] v2);
        logic [9:0] vals [3];
        vals[0] = v0; vals[1] = v1; vals[2] = v2;
        for (int i = 0; i < 3; i++) begin
            SW  = vals[i];
            KEY = 4'hD;
            tick(1);
            check($sformatf("load%0d", i + 1), {load_we, load_addr, load_data},
                  {1'b1, 5'(i + 1), 22'd0, vals[i]});
            KEY = 4'hF;
            tick(1);
        end
        check("load_done_state", 64'(state_o), 64'd1);
    endtask

    typedef struct packed {
        logic [3:0]  key;
        logic [9:0]  sw;
        logic [2:0]  st;
        logic        pc;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } vec_t;
    vec_t vq[$];

    task automatic addv(input logic [3:0] k, input logic [9:0] s, input logic [2:0] st,
                        input logic pc, input logic we, input logic [4:0] a, input logic [31:0] d);
        vec_t t;
        t.key = k; t.sw = s; t.st = st; t.pc = pc; t.we = we; t.addr = a; t.data = d;
        vq.push_back(t);
    endtask

    initial begin
        int exp_cnt;
        int exp_addr;
        int op, h, n, j, len;

        for (int i = 0; i < 32; i++) gpr[i] = 32'h0;
        gpr[1] = 32'h0000_0ABC;
        gpr[2] = 32'h0000_0155;
        gpr[3] = 32'hFFFF_F3C5;
`ifdef MIPS_DBG_BREAKPOINT_EN
        bp_pc    = 32'd0;
        bp_valid = 1'b0;
`endif

        // ---------------- reset values ----------------
        reset = 1'b1; KEY = 4'hF; SW = 10'd0;
        tick(2);
        check("reset", {state_o, pc_en, load_we, load_addr, load_data, dbg_rd_addr, LEDR},
              {3'd0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 10'd0});
        reset = 1'b0;

        // ---------------- vector table ----------------
        //   key    sw       st    pc    we    addr  data
        addv(4'hF, 10'd5,   3'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        addv(4'hD, 10'd5,   3'd0, 1'b0, 1'b1, 5'd1, 32'd5);
        addv(4'hD, 10'd5,   3'd0, 1'b0, 1'b0, 5'd1, 32'd5);
        addv(4'hF, 10'd10,  3'd0, 1'b0, 1'b0, 5'd1, 32'd5);
        addv(4'hD, 10'd10,  3'd0, 1'b0, 1'b1, 5'd2, 32'd10);
        addv(4'hF, 10'h3FF, 3'd0, 1'b0, 1'b0, 5'd2, 32'd10);
        addv(4'hD, 10'h3FF, 3'd1, 1'b0, 1'b1, 5'd3, 32'h3FF);
        addv(4'hF, 10'h3FF, 3'd1, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'hE, 10'h000, 3'd2, 1'b1, 1'b0, 5'd3, 32'h3FF);
        addv(4'hE, 10'h000, 3'd1, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'hF, 10'h000, 3'd1, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'hE, 10'h200, 3'd1, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'hF, 10'h200, 3'd1, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'hE, 10'h202, 3'd3, 1'b1, 1'b0, 5'd3, 32'h3FF);
        addv(4'hF, 10'h202, 3'd3, 1'b1, 1'b0, 5'd3, 32'h3FF);
        addv(4'hF, 10'h202, 3'd1, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'h7, 10'h000, 3'd4, 1'b1, 1'b0, 5'd3, 32'h3FF);
        addv(4'hF, 10'h000, 3'd4, 1'b1, 1'b0, 5'd3, 32'h3FF);
        addv(4'hE, 10'h000, 3'd4, 1'b1, 1'b0, 5'd3, 32'h3FF);
        addv(4'h6, 10'h000, 3'd1, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'hF, 10'h000, 3'd1, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'h6, 10'h000, 3'd4, 1'b1, 1'b0, 5'd3, 32'h3FF);
        addv(4'hF, 10'h000, 3'd4, 1'b1, 1'b0, 5'd3, 32'h3FF);
        addv(4'h7, 10'h000, 3'd1, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'hF, 10'h000, 3'd1, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'hD, 10'h000, 3'd0, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'hF, 10'h000, 3'd0, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'h6, 10'h000, 3'd0, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'hF, 10'h0AA, 3'd0, 1'b0, 1'b0, 5'd3, 32'h3FF);
        addv(4'hD, 10'h0AA, 3'd0, 1'b0, 1'b1, 5'd1, 32'h0AA);
        addv(4'hF, 10'h0AA, 3'd0, 1'b0, 1'b0, 5'd1, 32'h0AA);

        foreach (vq[i]) begin
            KEY = vq[i].key;
            SW  = vq[i].sw;
            tick(1);
            check($sformatf("vec%0d", i), {state_o, pc_en, load_we, load_addr, load_data},
                  {vq[i].st, vq[i].pc, vq[i].we, vq[i].addr, vq[i].data});
        end

        // ---------------- directed sequences ----------------
        do_reset();
        do_load(10'd5, 10'h155, 10'h3FF);

        // single step with the key held for 20 cycles
        clr_mon(); SW = 10'h000; KEY = 4'hE; tick(20); KEY = 4'hF; tick(2);
        check("step_held_cnt", 64'(pc_cnt), 64'd1);
        check("step_held_state", 64'(state_o), 64'd1);

        // burst of 7
        clr_mon(); SW = 10'h207; KEY = 4'hE; tick(1); KEY = 4'hF; tick(12);
        check("burst7_cnt", 64'(pc_cnt), 64'd7);
        check("burst7_runs", 64'(pc_bursts), 64'd1);
        check("burst7_state", 64'(state_o), 64'd1);

        // burst of 0
        clr_mon(); SW = 10'h200; KEY = 4'hE; tick(1);
        check("burst0_state_now", 64'(state_o), 64'd1);
        KEY = 4'hF; tick(4);
        check("burst0_cnt", 64'(pc_cnt), 64'd0);

        // run for 50 cycles, stop press also carries a KEY[0] edge
        clr_mon(); SW = 10'h000; KEY = 4'h7; tick(1); KEY = 4'hF; tick(50);
        KEY = 4'h6; tick(1); KEY = 4'hF; tick(5);
        check("run_cnt", 64'(pc_cnt), 64'd51);
        check("run_runs", 64'(pc_bursts), 64'd1);
        check("run_stop_state", 64'(state_o), 64'd1);

        // display select and wrap
        KEY = 4'hB; tick(1);
        check("disp_addr2", 64'(dbg_rd_addr), 64'd2);
        KEY = 4'hF; tick(1);
        check("disp_led2", 64'(LEDR), 64'h155);
        KEY = 4'hB; tick(1); KEY = 4'hF; tick(1);
        check("disp_addr3", 64'(dbg_rd_addr), 64'd3);
        check("disp_led3", 64'(LEDR), 64'h3C5);
        KEY = 4'hB; tick(1); KEY = 4'hF; tick(1);
        check("disp_wrap", 64'(dbg_rd_addr), 64'd1);

        // reset while running
        KEY = 4'h7; tick(1); KEY = 4'hF; tick(5);
        check("run_before_reset", 64'(pc_en), 64'd1);
        reset = 1'b1; tick(1);
        check("reset_mid_run", {state_o, pc_en}, {3'd0, 1'b0});
        reset = 1'b0; tick(1);

`ifdef MIPS_DBG_BREAKPOINT_EN
        // breakpoint stops RUN before the instruction at bp_pc
        do_reset();
        do_load(10'd1, 10'd2, 10'd3);
        bp_pc = 32'h10; bp_valid = 1'b1;
        clr_mon(); KEY = 4'h7; tick(1); KEY = 4'hF; tick(20);
        check("bp_run_cnt", 64'(pc_cnt), 64'd4);
        check("bp_pc_value", 64'(pc_in), 64'h10);
        check("bp_state", 64'(state_o), 64'd1);
        check("bp_pc_en_low", 64'(pc_en), 64'd0);
        clr_mon(); SW = 10'h000; KEY = 4'hE; tick(1); KEY = 4'hF; tick(3);
        check("bp_step_off", 64'(pc_cnt), 64'd1);
        bp_valid = 1'b0;
`endif

        // ---------------- randomized operations vs reference model ----------------
        do_reset();
        do_load(10'($urandom), 10'($urandom), 10'($urandom));
        exp_addr = 1;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 4);
            exp_cnt = 0;
            clr_mon();
            case (op)
                0: begin
                    h = $urandom_range(1, 6);
                    SW = {1'b0, 9'($urandom)};
                    KEY = 4'hE; tick(h); KEY = 4'hF;
                    exp_cnt = 1;
                end
                1: begin
                    n = $urandom_range(0, 30);
                    SW = {2'b10, 8'(n)};
                    KEY = 4'hE; tick(1); KEY = 4'hF;
                    exp_cnt = n;
                    if (n >= 2 && ($urandom % 3) == 0) begin
                        j = $urandom_range(1, n - 1);
                        tick(j - 1);
                        KEY = 4'h7; tick(1); KEY = 4'hF;
                        exp_cnt = j;
                    end
                    tick(n + 2);
                end
                2: begin
                    len = $urandom_range(1, 30);
                    KEY = 4'h7; tick(1); KEY = 4'hF; tick(len);
                    KEY = 4'h7; tick(1); KEY = 4'hF;
                    exp_cnt = len + 1;
                end
                3: begin
                    KEY = 4'hB; tick(1);
                    exp_addr = (exp_addr == 3) ? 1 : exp_addr + 1;
                    check("rnd_disp_addr", 64'(dbg_rd_addr), 64'(exp_addr));
                    KEY = 4'hF; tick(1);
                    check("rnd_disp_led", 64'(LEDR), 64'(gpr[exp_addr][9:0]));
                end
                default: begin
                    KEY = 4'hD; tick(1); KEY = 4'hF; tick(1);
                    check("rnd_reload_state", 64'(state_o), 64'd0);
                    if ($urandom % 2) begin
                        KEY = 4'h6; tick(1); KEY = 4'hF; tick(1);
                        check("rnd_load_ignores", 64'(state_o), 64'd0);
                    end
                    do_load(10'($urandom), 10'($urandom), 10'($urandom));
                end
            endcase
            tick(3);
            check("rnd_pc_cnt", 64'(pc_cnt), 64'(exp_cnt));
            check("rnd_pc_runs", 64'(pc_bursts), 64'(exp_cnt > 0 ? 1 : 0));
            check("rnd_state", 64'(state_o), 64'd1);
        end

        check("no_we_pc_overlap", 64'(overlap_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
